// File: rtl/sysgen_pkg.sv
// Shared definitions for the systolic array sequencer: state encoding,
// reduction-counter width helper and lane slicing for packed lane vectors.
`ifndef SYSGEN_LANE
`define SYSGEN_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package sysgen_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      HOLD  = 3'd4
   } state_e;

   localparam int PerfWidth = 32;

   // Width of a counter able to hold every value 0..kMax inclusive.
   function automatic int kw(input int kMax);
      return $clog2(kMax + 1);
   endfunction

endpackage

// File: rtl/skew_buffer.sv
// Per-lane delay line that staggers an array edge: lane i is delayed i cycles,
// lane 0 passes straight through.
module skew_buffer
   import sysgen_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [LANES*DATA_WIDTH-1:0] data_i,
   output logic [LANES*DATA_WIDTH-1:0] data_o
);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      if (i == 0) begin : g_pass
         assign `SYSGEN_LANE(data_o, i, DATA_WIDTH) = `SYSGEN_LANE(data_i, i, DATA_WIDTH);
      end else begin : g_delay
         logic [DATA_WIDTH-1:0] shift_q [i];

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int j = 0; j < i; j++) shift_q[j] <= '0;
            end else begin
               shift_q[0] <= `SYSGEN_LANE(data_i, i, DATA_WIDTH);
               for (int j = 1; j < i; j++) shift_q[j] <= shift_q[j-1];
            end
         end

         assign `SYSGEN_LANE(data_o, i, DATA_WIDTH) = shift_q[i-1];
      end
   end

endmodule

// File: rtl/systolic_mac_ctrl.sv
// Sequencer for an output-stationary systolic MAC array: clear, feed skewed
// operands, drain the wavefront, hold results. SYSGEN_PERF_CNT_EN adds perf_cycles_o.
module systolic_mac_ctrl
   import sysgen_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int ROWS       = 4,
   parameter  int COLS       = 4,
   parameter  int K_MAX      = 256,
   localparam int KW         = kw(K_MAX)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       start_i,
   input  logic [KW-1:0]              k_len_i,
   output logic                       busy_o,
   output logic                       done_o,
   input  logic                       res_ack_i,
   output logic                       a_rd_en_o,
   output logic                       b_rd_en_o,
   output logic [KW-1:0]              a_rd_addr_o,
   output logic [KW-1:0]              b_rd_addr_o,
   input  logic [ROWS*DATA_WIDTH-1:0] a_rd_data_i,
   input  logic [COLS*DATA_WIDTH-1:0] b_rd_data_i,
   output logic [ROWS*DATA_WIDTH-1:0] row_in_o,
   output logic [COLS*DATA_WIDTH-1:0] col_in_o,
   output logic                       pe_clr_n_o
`ifdef SYSGEN_PERF_CNT_EN
   ,
   output logic [PerfWidth-1:0]       perf_cycles_o
`endif
);

   localparam int            DCW       = $clog2(ROWS + COLS + 1);
   localparam logic [KW-1:0] KMaxW     = KW'(K_MAX);
   localparam logic [DCW-1:0] LastDrain = DCW'(ROWS + COLS - 1);

   state_e               state_q, state_d;
   logic [KW-1:0]        kLen_q, kLen_d;
   logic [KW-1:0]        addr_q, addr_d;
   logic [DCW-1:0]       drainCnt_q, drainCnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 rdEn_q, rdEn_d;
   logic                 clrN_q, clrN_d;
   logic                 rdValid_q;
   logic [ROWS*DATA_WIDTH-1:0] aIn_q;
   logic [COLS*DATA_WIDTH-1:0] bIn_q;

   // Outputs are decoded from the next state so every output is a flop.
   always_comb begin
      state_d    = state_q;
      kLen_d     = kLen_q;
      addr_d     = '0;
      drainCnt_d = '0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = CLEAR;
               kLen_d  = (k_len_i > KMaxW) ? KMaxW : k_len_i;
            end
         end
         CLEAR: state_d = (kLen_q == '0) ? DRAIN : FEED;
         FEED: begin
            if (addr_q == kLen_q - KW'(1)) state_d = DRAIN;
            else                           addr_d  = addr_q + KW'(1);
         end
         DRAIN: begin
            if (drainCnt_q == LastDrain) state_d    = HOLD;
            else                         drainCnt_d = drainCnt_q + DCW'(1);
         end
         HOLD: begin
            if (res_ack_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == HOLD);
      rdEn_d = (state_d == FEED);
      clrN_d = (state_d != CLEAR);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         kLen_q     <= '0;
         addr_q     <= '0;
         drainCnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rdEn_q     <= 1'b0;
         clrN_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         kLen_q     <= kLen_d;
         addr_q     <= addr_d;
         drainCnt_q <= drainCnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rdEn_q     <= rdEn_d;
         clrN_q     <= clrN_d;
      end
   end

   // Buffer data lands one cycle after the strobe; non-read cycles feed zeros.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdValid_q <= 1'b0;
         aIn_q     <= '0;
         bIn_q     <= '0;
      end else begin
         rdValid_q <= rdEn_q;
         aIn_q     <= rdValid_q ? a_rd_data_i : '0;
         bIn_q     <= rdValid_q ? b_rd_data_i : '0;
      end
   end

   skew_buffer #(.DATA_WIDTH(DATA_WIDTH), .LANES(ROWS)) u_skew_a (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .data_i (aIn_q),
      .data_o (row_in_o)
   );

   skew_buffer #(.DATA_WIDTH(DATA_WIDTH), .LANES(COLS)) u_skew_b (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .data_i (bIn_q),
      .data_o (col_in_o)
   );

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign a_rd_en_o   = rdEn_q;
   assign b_rd_en_o   = rdEn_q;
   assign a_rd_addr_o = addr_q;
   assign b_rd_addr_o = addr_q;
   assign pe_clr_n_o  = clrN_q;

`ifdef SYSGEN_PERF_CNT_EN
   logic [PerfWidth-1:0] perf_q;

   // Counts CLEAR/FEED/DRAIN cycles of the latest job, saturating.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_q <= '0;
      end else if (state_q == IDLE && start_i) begin
         perf_q <= '0;
      end else if ((state_q == CLEAR || state_q == FEED || state_q == DRAIN) && perf_q != '1) begin
         perf_q <= perf_q + PerfWidth'(1);
      end
   end

   assign perf_cycles_o = perf_q;
`endif

endmodule
